// File: rtl/id_ex_pipeline_reg_if.sv
// ID/EX boundary bundle: decoded ID fields in, registered EX fields, stall and counters out.
// The master drives the ID side; the slave is the pipeline register itself.
interface id_ex_pipeline_reg_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) ();
  logic            valid_id;
  logic [XLEN-1:0] pc_id;
  logic [RA_W-1:0] rs1_id;
  logic [RA_W-1:0] rs2_id;
  logic            use_rs1_id;
  logic            use_rs2_id;
  logic [RA_W-1:0] rd_id;
  logic [XLEN-1:0] rs1_data_id;
  logic [XLEN-1:0] rs2_data_id;
  logic [XLEN-1:0] imm_id;
  logic [3:0]      alu_op_id;
  logic            alu_src_id;
  logic            RegWrite_id;
  logic            MemRead_id;
  logic            MemWrite_id;
  logic            MemToReg_id;
  logic            flush_ex;

  logic            stall_if_id;
  logic            valid_ex;
  logic [XLEN-1:0] pc_ex;
  logic [RA_W-1:0] rs1_ex;
  logic [RA_W-1:0] rs2_ex;
  logic [RA_W-1:0] rd_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] imm_ex;
  logic [3:0]      alu_op_ex;
  logic            alu_src_ex;
  logic            RegWrite_ex;
  logic            MemRead_ex;
  logic            MemWrite_ex;
  logic            MemToReg_ex;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output valid_id, pc_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, rs1_data_id,
           rs2_data_id, imm_id, alu_op_id, alu_src_id, RegWrite_id, MemRead_id, MemWrite_id,
           MemToReg_id, flush_ex,
    input  stall_if_id, valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex,
           imm_ex, alu_op_ex, alu_src_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex,
           bubble_cnt, flush_cnt
  );

  modport slave (
    input  valid_id, pc_id, rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, rs1_data_id,
           rs2_data_id, imm_id, alu_op_id, alu_src_id, RegWrite_id, MemRead_id, MemWrite_id,
           MemToReg_id, flush_ex,
    output stall_if_id, valid_ex, pc_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex,
           imm_ex, alu_op_ex, alu_src_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemToReg_ex,
           bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and saturating
// bubble/flush counters.
module id_ex_pipeline_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  id_ex_pipeline_reg_if.slave bus
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_alu_op;
  logic            r_alu_src;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_bubble;

  // Hazard is judged against the registered EX stage, so it always sees the real load.
  assign w_rs1_hit  = bus.use_rs1_id & (bus.rs1_id == r_rd);
  assign w_rs2_hit  = bus.use_rs2_id & (bus.rs2_id == r_rd);
  assign w_load_use = r_valid & r_mem_read & (r_rd != '0) & bus.valid_id & (w_rs1_hit | w_rs2_hit);
  assign w_bubble   = bus.flush_ex | w_load_use;

  assign bus.stall_if_id = w_load_use & ~bus.flush_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_valid      <= bus.valid_id;
      r_pc         <= bus.pc_id;
      r_rs1        <= bus.rs1_id;
      r_rs2        <= bus.rs2_id;
      r_rd         <= bus.rd_id;
      r_rs1_data   <= bus.rs1_data_id;
      r_rs2_data   <= bus.rs2_data_id;
      r_imm        <= bus.imm_id;
      r_alu_op     <= bus.alu_op_id;
      r_alu_src    <= bus.alu_src_id;
      // An empty ID slot must never write anything downstream.
      r_reg_write  <= bus.valid_id & bus.RegWrite_id;
      r_mem_read   <= bus.valid_id & bus.MemRead_id;
      r_mem_write  <= bus.valid_id & bus.MemWrite_id;
      r_mem_to_reg <= bus.valid_id & bus.MemToReg_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (bus.flush_ex) begin
      if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end else if (w_load_use) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.valid_ex    = r_valid;
  assign bus.pc_ex       = r_pc;
  assign bus.rs1_ex      = r_rs1;
  assign bus.rs2_ex      = r_rs2;
  assign bus.rd_ex       = r_rd;
  assign bus.rs1_data_ex = r_rs1_data;
  assign bus.rs2_data_ex = r_rs2_data;
  assign bus.imm_ex      = r_imm;
  assign bus.alu_op_ex   = r_alu_op;
  assign bus.alu_src_ex  = r_alu_src;
  assign bus.RegWrite_ex = r_reg_write;
  assign bus.MemRead_ex  = r_mem_read;
  assign bus.MemWrite_ex = r_mem_write;
  assign bus.MemToReg_ex = r_mem_to_reg;
  assign bus.bubble_cnt  = r_bubble_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench: directed ID vectors queue their hand-derived EX state; a monitor pops
// and compares on each falling clock edge and on asynchronous reset assertion.
module tb_id_ex_pipeline_reg;

  logic clk;
  logic rst_n;

  id_ex_pipeline_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) if_m ();
  id_ex_pipeline_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(4))  if_s ();

  id_ex_pipeline_reg #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  id_ex_pipeline_reg #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, rw, mr, mw, fl;
    logic [31:0] pc;
  } id_t;

  typedef struct {
    int          idx;
    logic        stall, v;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw;
    logic [31:0] pc;
    int          bub, flc;
  } ex_t;

  ex_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  row      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic id_t mk_id(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic u1, logic u2, logic rw, logic mr, logic mw, logic fl,
                                logic [31:0] pc);
    id_t d;
    d.v = v; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.u1 = u1; d.u2 = u2;
    d.rw = rw; d.mr = mr; d.mw = mw; d.fl = fl; d.pc = pc;
    return d;
  endfunction

  function automatic ex_t mk_ex(logic stall, logic v, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic rw, logic mr, logic mw, logic [31:0] pc,
                                int bub, int flc);
    ex_t e;
    e.idx = 0; e.stall = stall; e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.pc = pc; e.bub = bub; e.flc = flc;
    return e;
  endfunction

  function automatic logic [31:0] dat(logic [31:0] pc, logic [31:0] k);
    return (pc == 32'd0) ? 32'd0 : pc + k;
  endfunction

  function automatic int sat15(int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic drive(input id_t d);
    if_m.valid_id = d.v;       if_s.valid_id = d.v;
    if_m.pc_id = d.pc;         if_s.pc_id = d.pc;
    if_m.rs1_id = d.rs1;       if_s.rs1_id = d.rs1;
    if_m.rs2_id = d.rs2;       if_s.rs2_id = d.rs2;
    if_m.use_rs1_id = d.u1;    if_s.use_rs1_id = d.u1;
    if_m.use_rs2_id = d.u2;    if_s.use_rs2_id = d.u2;
    if_m.rd_id = d.rd;         if_s.rd_id = d.rd;
    if_m.rs1_data_id = dat(d.pc, 32'd1);  if_s.rs1_data_id = dat(d.pc, 32'd1);
    if_m.rs2_data_id = dat(d.pc, 32'd2);  if_s.rs2_data_id = dat(d.pc, 32'd2);
    if_m.imm_id = dat(d.pc, 32'd3);       if_s.imm_id = dat(d.pc, 32'd3);
    if_m.alu_op_id = d.pc[5:2];  if_s.alu_op_id = d.pc[5:2];
    if_m.alu_src_id = d.pc[2];   if_s.alu_src_id = d.pc[2];
    if_m.RegWrite_id = d.rw;     if_s.RegWrite_id = d.rw;
    if_m.MemRead_id = d.mr;      if_s.MemRead_id = d.mr;
    if_m.MemWrite_id = d.mw;     if_s.MemWrite_id = d.mw;
    if_m.MemToReg_id = d.mr;     if_s.MemToReg_id = d.mr;
    if_m.flush_ex = d.fl;        if_s.flush_ex = d.fl;
  endtask

  // Apply one ID vector just after a rising edge and queue the EX state seen this cycle.
  task automatic step(input id_t d, input ex_t e);
    @(posedge clk);
    #1;
    drive(d);
    e.idx = row;
    row++;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  // Monitor: compares after every falling clock edge and right after reset assertion.
  initial begin
    ex_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_if_id", e.idx, 64'(if_m.stall_if_id), 64'(e.stall));
        chk("valid_ex",    e.idx, 64'(if_m.valid_ex),    64'(e.v));
        chk("rs1_ex",      e.idx, 64'(if_m.rs1_ex),      64'(e.rs1));
        chk("rs2_ex",      e.idx, 64'(if_m.rs2_ex),      64'(e.rs2));
        chk("rd_ex",       e.idx, 64'(if_m.rd_ex),       64'(e.rd));
        chk("RegWrite_ex", e.idx, 64'(if_m.RegWrite_ex), 64'(e.rw));
        chk("MemRead_ex",  e.idx, 64'(if_m.MemRead_ex),  64'(e.mr));
        chk("MemWrite_ex", e.idx, 64'(if_m.MemWrite_ex), 64'(e.mw));
        chk("MemToReg_ex", e.idx, 64'(if_m.MemToReg_ex), 64'(e.mr));
        chk("pc_ex",       e.idx, 64'(if_m.pc_ex),       64'(e.pc));
        chk("rs1_data_ex", e.idx, 64'(if_m.rs1_data_ex), 64'(dat(e.pc, 32'd1)));
        chk("rs2_data_ex", e.idx, 64'(if_m.rs2_data_ex), 64'(dat(e.pc, 32'd2)));
        chk("imm_ex",      e.idx, 64'(if_m.imm_ex),      64'(dat(e.pc, 32'd3)));
        chk("alu_op_ex",   e.idx, 64'(if_m.alu_op_ex),   64'(e.pc[5:2]));
        chk("alu_src_ex",  e.idx, 64'(if_m.alu_src_ex),  64'(e.pc[2]));
        chk("bubble_cnt",  e.idx, 64'(if_m.bubble_cnt),  64'(e.bub));
        chk("flush_cnt",   e.idx, 64'(if_m.flush_cnt),   64'(e.flc));
        chk("sat_bubble_cnt", e.idx, 64'(if_s.bubble_cnt), 64'(sat15(e.bub)));
        chk("sat_flush_cnt",  e.idx, 64'(if_s.flush_cnt),  64'(sat15(e.flc)));
        chk("sat_stall",      e.idx, 64'(if_s.stall_if_id), 64'(e.stall));
      end
    end
  end

  initial begin
    id_t idle;
    id_t add_dep;
    idle    = mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    add_dep = mk_id(1, 5, 7, 6, 1, 1, 1, 0, 0, 0, 32'h504);
    rst_n = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic flow, load-use stall, rd=0 load, unused rs2, flush over load-use, empty slot.
    step(idle, mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    step(mk_id(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 32'h100), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    step(mk_id(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 32'h104), mk_ex(0, 1, 1, 2, 3, 1, 0, 0, 32'h100, 0, 0));
    step(mk_id(1, 5, 7, 6, 1, 1, 1, 0, 0, 0, 32'h108), mk_ex(1, 1, 1, 0, 5, 1, 1, 0, 32'h104, 0, 0));
    step(mk_id(1, 5, 7, 6, 1, 1, 1, 0, 0, 0, 32'h108), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
    step(mk_id(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 32'h10C), mk_ex(0, 1, 5, 7, 6, 1, 0, 0, 32'h108, 1, 0));
    step(mk_id(1, 0, 0, 6, 1, 1, 1, 0, 0, 0, 32'h110), mk_ex(0, 1, 1, 0, 0, 1, 1, 0, 32'h10C, 1, 0));
    step(mk_id(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 32'h114), mk_ex(0, 1, 0, 0, 6, 1, 0, 0, 32'h110, 1, 0));
    step(mk_id(1, 1, 5, 8, 1, 0, 1, 0, 0, 0, 32'h118), mk_ex(0, 1, 1, 0, 5, 1, 1, 0, 32'h114, 1, 0));
    step(mk_id(1, 2, 0, 5, 1, 0, 1, 1, 0, 0, 32'h11C), mk_ex(0, 1, 1, 5, 8, 1, 0, 0, 32'h118, 1, 0));
    step(mk_id(1, 5, 5, 9, 1, 1, 1, 0, 0, 1, 32'h120), mk_ex(0, 1, 2, 0, 5, 1, 1, 0, 32'h11C, 1, 0));
    step(idle, mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    step(mk_id(1, 2, 3, 0, 1, 1, 0, 0, 1, 0, 32'h124), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    step(mk_id(0, 4, 0, 7, 1, 0, 1, 1, 1, 0, 32'h128), mk_ex(0, 1, 2, 3, 0, 0, 0, 1, 32'h124, 1, 1));
    step(mk_id(1, 7, 0, 9, 1, 0, 1, 0, 0, 0, 32'h12C), mk_ex(0, 0, 4, 0, 7, 0, 0, 0, 32'h128, 1, 1));
    step(idle, mk_ex(0, 1, 7, 0, 9, 1, 0, 0, 32'h12C, 1, 1));
    step(idle, mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));

    // Twenty load-use pairs: the 4-bit bubble counter must stick at 15.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] p;
      p = 32'h200 + 32'(i) * 32'd16;
      if (i == 0)
        step(mk_id(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, p), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
      else
        step(mk_id(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, p),
             mk_ex(0, 1, 5, 7, 6, 1, 0, 0, p - 32'd12, 1 + i, 1));
      step(mk_id(1, 5, 7, 6, 1, 1, 1, 0, 0, 0, p + 32'd4), mk_ex(1, 1, 1, 0, 5, 1, 1, 0, p, 1 + i, 1));
      step(mk_id(1, 5, 7, 6, 1, 1, 1, 0, 0, 0, p + 32'd4), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 2 + i, 1));
    end

    // Twenty flush cycles: the 4-bit flush counter must stick at 15.
    for (int j = 0; j < 20; j++) begin
      if (j == 0)
        step(mk_id(1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 32'h400),
             mk_ex(0, 1, 5, 7, 6, 1, 0, 0, 32'h334, 21, 1));
      else
        step(mk_id(1, 1, 2, 3, 1, 1, 1, 0, 0, 1, 32'h400 + 32'(j) * 32'd4),
             mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 21, 1 + j));
    end
    step(idle, mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 21, 21));

    // Reset while a stall is being requested; outputs must clear before the next edge.
    step(mk_id(1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 32'h500), mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 21, 21));
    step(add_dep, mk_ex(1, 1, 1, 0, 5, 1, 1, 0, 32'h500, 21, 21));
    #6;
    exp_q.push_back(mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(idle, mk_ex(0, 1, 5, 7, 6, 1, 0, 0, 32'h504, 0, 0));
    step(idle, mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
